// File: rtl/fmlarb_n.sv
// N-master FML arbiter: master 0 priority, round-robin over the rest.
// Optional macro FMLARB_N_QUOTA_EN bounds consecutive master-0 grants.
module fmlarb_n #(
    parameter int N_MASTERS = 6,
    parameter int fml_depth = 26,
    parameter int fml_width = 32,
    parameter int READ_LAT  = 4,
    parameter int QUOTA     = 4
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic [N_MASTERS*fml_depth-1:0]    m_adr,
    input  logic [N_MASTERS-1:0]              m_stb,
    input  logic [N_MASTERS-1:0]              m_we,
    input  logic [N_MASTERS*fml_width/8-1:0]  m_sel,
    input  logic [N_MASTERS*fml_width-1:0]    m_di,
    output logic [N_MASTERS-1:0]              m_ack,
    output logic [fml_width-1:0]              m_do,
    output logic [fml_depth-1:0]              s_adr,
    output logic                              s_stb,
    output logic                              s_we,
    input  logic                              s_eack,
    output logic [fml_width/8-1:0]            s_sel,
    output logic [fml_width-1:0]              s_do,
    input  logic [fml_width-1:0]              s_di
);

    localparam int MW = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1;
    localparam int SW = fml_width / 8;

    logic [MW-1:0]        master;
    logic [MW-1:0]        master_d;
    logic [MW-1:0]        wmaster;
    logic [MW-1:0]        msel;
    logic [MW-1:0]        cand;
    logic [N_MASTERS-1:0] pending;
    logic [N_MASTERS-1:0] stbm;
    logic [N_MASTERS-1:0] rd_set;
    logic [N_MASTERS-1:0] rd_ack;
    logic [N_MASTERS-1:0] wr_ack;
    logic [READ_LAT-1:0]  rd_line [N_MASTERS];
    logic                 acc;
    logic                 win0;
    logic                 found;
    int                   base;

    assign stbm  = m_stb & ~pending;
    // Reset forces the slave side to look at master 0 only.
    assign msel  = sys_rst ? '0 : master;
    assign s_adr = m_adr[int'(msel)*fml_depth +: fml_depth];
    assign s_we  = m_we[msel];
    assign s_stb = sys_rst ? m_stb[0] : stbm[master];
    assign acc   = s_stb & s_eack & ~sys_rst;

    assign s_do  = m_di[int'(wmaster)*fml_width +: fml_width];
    assign s_sel = m_sel[int'(wmaster)*SW +: SW];
    assign m_do  = s_di;
    assign m_ack = sys_rst ? '0 : (rd_ack | wr_ack);

    always_comb begin
        rd_set = '0;
        wr_ack = '0;
        rd_ack = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            rd_set[i] = acc & ~s_we & (master == MW'(i));
            wr_ack[i] = acc & s_we & (master == MW'(i));
            rd_ack[i] = rd_line[i][READ_LAT-1];
        end
    end

`ifdef FMLARB_N_QUOTA_EN
    localparam int QW = $clog2(QUOTA + 2);

    logic [QW-1:0] qcnt;
    logic [QW-1:0] qcnt_d;
    logic          others;
    logic          counting;
    logic          lose0;

    assign others   = |stbm[N_MASTERS-1:1];
    assign counting = acc & (master == '0) & others;
    assign lose0    = counting & (int'(qcnt) + 1 >= QUOTA);

    always_comb begin
        qcnt_d = qcnt;
        if (!others || master_d != '0)
            qcnt_d = '0;
        else if (counting)
            qcnt_d = qcnt + QW'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            qcnt <= '0;
        else
            qcnt <= qcnt_d;
    end
`endif

    always_comb begin
        master_d = master;
        found    = 1'b0;
        cand     = '0;
        win0     = (master == '0) ? m_stb[0] : stbm[0];
`ifdef FMLARB_N_QUOTA_EN
        if (lose0)
            win0 = 1'b0;
`endif
        base = (int'(master) >= N_MASTERS - 1) ? 1 : int'(master) + 1;
        if (!stbm[master] || s_eack) begin
            if (win0) begin
                master_d = '0;
            end else begin
                // Scan 1..N-1 starting after the current owner.
                for (int k = 0; k < N_MASTERS - 1; k++) begin
                    cand = MW'((base - 1 + k) % (N_MASTERS - 1) + 1);
                    if (!found && stbm[cand]) begin
                        master_d = cand;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            master  <= '0;
            wmaster <= '0;
            pending <= '0;
            for (int i = 0; i < N_MASTERS; i++)
                rd_line[i] <= '0;
        end else begin
            master  <= master_d;
            if (acc && s_we)
                wmaster <= master;
            pending <= (pending & ~rd_ack) | rd_set;
            for (int i = 0; i < N_MASTERS; i++)
                rd_line[i] <= (rd_line[i] << 1) | READ_LAT'(rd_set[i]);
        end
    end

endmodule
